// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source encodings, fetch FSM states and reset constants.
// Imported by the fetch unit and anything that drives its mux_pc select.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4 = 2'b00,
        PC_SRC_ALU   = 2'b01,
        PC_SRC_JUMP  = 2'b10,
        PC_SRC_EPC   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_DONE = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC              = 32'h0000_0000;
    localparam int          FETCH_TIMEOUT_DEFAULT = 15;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// The request is level-held; memory answers with a single-cycle ready strobe.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rd_data,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rd_data,
        output mem_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC and instruction register, runs the memory read
// handshake with timeout, and computes the next-PC candidates for the control unit.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_in,
    input  logic                fetch_start,
    input  logic                pc_write_enable,
    input  logic [1:0]          mux_pc,
    input  logic [31:0]         alu_result,
    input  logic [31:0]         epc_in,
    fetch_unit_if.master        mem,
    output logic [31:0]         pc,
    output logic [31:0]         instruction,
    output logic [31:0]         pc_plus4,
    output logic [31:0]         jump_target,
    output logic [31:0]         link_addr,
    output logic                fetch_done,
    output logic                fetch_error,
    output logic                align_error,
    output logic                busy
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(FETCH_TIMEOUT);

    fetch_state_e state_q, state_d;
    logic [3:0]   wait_cnt_q, wait_cnt_d;
    logic [3:0]   wait_cnt_inc;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         fetch_done_q, fetch_done_d;
    logic         fetch_error_q, fetch_error_d;
    logic         align_error_q, align_error_d;

    logic [31:0]  pc_plus4_w;
    logic [31:0]  jump_target_w;
    logic [31:0]  pc_src_w;
    logic         src_needs_check;

    assign pc_plus4_w    = pc_q + 32'd4;
    assign jump_target_w = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    assign wait_cnt_inc  = wait_cnt_q + 4'd1;

    // Only the datapath-supplied sources can be misaligned; pc+4 and J-targets never are.
    always_comb begin
        pc_src_w        = pc_plus4_w;
        src_needs_check = 1'b0;
        case (pc_src_e'(mux_pc))
            PC_SRC_PLUS4: pc_src_w = pc_plus4_w;
            PC_SRC_ALU: begin
                pc_src_w        = alu_result;
                src_needs_check = 1'b1;
            end
            PC_SRC_JUMP:  pc_src_w = jump_target_w;
            PC_SRC_EPC: begin
                pc_src_w        = epc_in;
                src_needs_check = 1'b1;
            end
            default:      pc_src_w = pc_plus4_w;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        fetch_done_d  = 1'b0;
        fetch_error_d = 1'b0;
        align_error_d = 1'b0;

        // PC is frozen while a request is outstanding so mem_addr cannot move under memory.
        if (pc_write_enable && (state_q != FETCH_REQ)) begin
            if (src_needs_check && !is_word_aligned(pc_src_w)) begin
                align_error_d = 1'b1;
            end else begin
                pc_d = pc_src_w;
            end
        end

        case (state_q)
            FETCH_IDLE: begin
                if (fetch_start) begin
                    state_d    = FETCH_REQ;
                    wait_cnt_d = 4'd0;
                end
            end
            FETCH_REQ: begin
                if (mem.mem_ready) begin
                    instr_d = mem.mem_rd_data;
                    state_d = FETCH_DONE;
                end else if (wait_cnt_inc == TIMEOUT_CNT) begin
                    fetch_error_d = 1'b1;
                    wait_cnt_d    = 4'd0;
                    state_d       = FETCH_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            FETCH_DONE: begin
                fetch_done_d = 1'b1;
                state_d      = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q       <= FETCH_IDLE;
            wait_cnt_q    <= 4'd0;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            fetch_done_q  <= 1'b0;
            fetch_error_q <= 1'b0;
            align_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fetch_done_q  <= fetch_done_d;
            fetch_error_q <= fetch_error_d;
            align_error_q <= align_error_d;
        end
    end

    // Status strobes are masked by reset so nothing stale leaks out during the reset cycle.
    assign mem.mem_req  = (state_q == FETCH_REQ) && !reset_in;
    assign mem.mem_addr = pc_q;
    assign busy         = ((state_q == FETCH_REQ) || (state_q == FETCH_DONE)) && !reset_in;
    assign fetch_done   = fetch_done_q  && !reset_in;
    assign fetch_error  = fetch_error_q && !reset_in;
    assign align_error  = align_error_q && !reset_in;

    assign pc          = pc_q;
    assign instruction = instr_q;
    assign pc_plus4    = pc_plus4_w;
    assign jump_target = jump_target_w;
    assign link_addr   = pc_plus4_w;

endmodule
